// File: rtl/video_gray2rgb_gen.sv
// Pseudo-colour expander: maps a gray level to an RGB colour through a programmable palette.
// Optional macro VIDEO_GRAY2RGB_BYPASS_EN adds a per-pixel bypass input that emits {idx,idx,idx}.
module video_gray2rgb_gen #(
    parameter int RSIZE    = 4,
    parameter int GSIZE    = 4,
    parameter int BSIZE    = 4,
    parameter int RGB_SIZE = RSIZE + GSIZE + BSIZE,
    parameter int SIZE     = RGB_SIZE / 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RGB_SIZE-1:0] src_rgb,
    input  logic                src_vld,
    output logic                src_rdy,
    output logic [RGB_SIZE-1:0] snk_rgb,
    output logic                snk_vld,
    input  logic                snk_rdy,
    input  logic                pal_write,
    input  logic [SIZE-1:0]     pal_addr,
    input  logic [RGB_SIZE-1:0] pal_wdata,
    output logic                pal_rdy
`ifdef VIDEO_GRAY2RGB_BYPASS_EN
    ,
    input  logic                bypass
`endif
);

    localparam int DEPTH = 2 ** SIZE;

    generate
        if (!(RSIZE == GSIZE && GSIZE == BSIZE)) begin : g_size_check
            $error("video_gray2rgb_gen: RSIZE, GSIZE and BSIZE must be equal");
        end
    endgenerate

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state;
    logic [SIZE-1:0]     cnt;
    logic [RGB_SIZE-1:0] palette [DEPTH];

    logic                adv;
    logic                accept;
    logic                vld0;
    logic [SIZE-1:0]     idx0;
    logic [SIZE-1:0]     src_idx;
    logic [RGB_SIZE-1:0] s1_data;
    logic                unused_src_lsbs;

    // Valid/ready: a beat transfers on a rising edge where valid and ready are both 1;
    // the whole two-stage pipeline advances only when the output slot is empty or being taken.
    assign adv     = ~snk_vld | snk_rdy;
    assign src_rdy = (state == ST_RUN) & adv;
    assign accept  = src_vld & src_rdy;
    assign src_idx = src_rgb[RGB_SIZE-1 -: SIZE];

    assign unused_src_lsbs = ^src_rgb[RGB_SIZE-SIZE-1:0];

    // Identity ramp fill after reset, then run forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            cnt     <= '0;
            pal_rdy <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == {SIZE{1'b1}}) begin
                        state   <= ST_RUN;
                        pal_rdy <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state   <= ST_RUN;
                    pal_rdy <= 1'b1;
                end
                default: begin
                    state   <= ST_INIT;
                    pal_rdy <= 1'b0;
                end
            endcase
        end
    end

    // Palette storage is not reset; INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            palette[cnt] <= {cnt, cnt, cnt};
        end else if (pal_write && pal_rdy) begin
            palette[pal_addr] <= pal_wdata;
        end
    end

`ifdef VIDEO_GRAY2RGB_BYPASS_EN
    logic byp0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp0 <= 1'b0;
        end else if (adv && accept) begin
            byp0 <= bypass;
        end
    end

    always_comb begin
        s1_data = palette[idx0];
        if (byp0) begin
            s1_data = {idx0, idx0, idx0};
        end
    end
`else
    always_comb begin
        s1_data = palette[idx0];
    end
`endif

    // Stage 1 reads the palette on the same edge a write lands, so a colliding write is seen next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0    <= 1'b0;
            idx0    <= '0;
            snk_vld <= 1'b0;
            snk_rgb <= '0;
        end else if (adv) begin
            vld0 <= accept;
            if (accept) begin
                idx0 <= src_idx;
            end
            snk_vld <= vld0;
            if (vld0) begin
                snk_rgb <= s1_data;
            end
        end
    end

endmodule

// File: tb/tb_video_gray2rgb_gen.sv
// Self-checking bench for video_gray2rgb_gen: directed cases plus a randomized stream
// scored against a palette-lookup reference model.
module tb_video_gray2rgb_gen;

    localparam int W = 12;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] src_rgb;
    logic         src_vld;
    logic         src_rdy;
    logic [W-1:0] snk_rgb;
    logic         snk_vld;
    logic         snk_rdy;
    logic         pal_write;
    logic [S-1:0] pal_addr;
    logic [W-1:0] pal_wdata;
    logic         pal_rdy;
`ifdef VIDEO_GRAY2RGB_BYPASS_EN
    logic         byp_drv = 1'b0;
`endif

    int           n_checks = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] pal_model[16];
    bit           model_run = 1'b0;

    always #5 clk = ~clk;

    video_gray2rgb_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_rgb   (src_rgb),
        .src_vld   (src_vld),
        .src_rdy   (src_rdy),
        .snk_rgb   (snk_rgb),
        .snk_vld   (snk_vld),
        .snk_rdy   (snk_rdy),
        .pal_write (pal_write),
        .pal_addr  (pal_addr),
        .pal_wdata (pal_wdata),
        .pal_rdy   (pal_rdy)
`ifdef VIDEO_GRAY2RGB_BYPASS_EN
        ,
        .bypass    (byp_drv)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the colour is simply the palette entry for the top gray field, or the
    // replicated gray level when bypassing.
    function automatic logic [W-1:0] expect_colour(input logic [W-1:0] pix, input bit byp);
        logic [S-1:0] g;
        g = pix[W-1 -: S];
        if (byp) return {g, g, g};
        return pal_model[g];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (snk_vld) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 12'(snk_vld), 12'd0);
                end else begin
                    check("out_rgb", snk_rgb, exp_q[0]);
                    if (snk_rdy) void'(exp_q.pop_front());
                end
            end
            if (src_vld && src_rdy) begin
`ifdef VIDEO_GRAY2RGB_BYPASS_EN
                exp_q.push_back(expect_colour(src_rgb, byp_drv));
`else
                exp_q.push_back(expect_colour(src_rgb, 1'b0));
`endif
            end
            if (model_run) begin
                check("run_pal_rdy", 12'(pal_rdy), 12'd1);
                if (snk_rdy) check("run_src_rdy_free", 12'(src_rdy), 12'd1);
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_snk_vld", 12'(snk_vld), 12'd0);
        check("rst_src_rdy", 12'(src_rdy), 12'd0);
        check("rst_pal_rdy", 12'(pal_rdy), 12'd0);
        exp_q.delete();
        model_run = 1'b0;
        src_vld   = 1'b0;
        pal_write = 1'b0;
        snk_rdy   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pal_model[i] = {S'(i), S'(i), S'(i)};
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_snk_rgb", snk_rgb, 12'd0);
        rst_n = 1'b1;
    endtask

    // Holds a source pixel and a palette write through INIT; both must be refused for 16 cycles.
    task automatic run_init();
        src_vld   = 1'b1;
        src_rgb   = 12'h777;
        pal_write = 1'b1;
        pal_addr  = 4'd7;
        pal_wdata = 12'hABC;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("init_src_rdy", 12'(src_rdy), 12'd0);
            check("init_pal_rdy", 12'(pal_rdy), 12'd0);
        end
        pal_write = 1'b0;
        @(negedge clk);
        check("first_src_rdy", 12'(src_rdy), 12'd1);
        check("first_pal_rdy", 12'(pal_rdy), 12'd1);
        @(posedge clk);
        #1;
        src_vld   = 1'b0;
        model_run = 1'b1;
        @(negedge clk);
        check("lat_early_vld", 12'(snk_vld), 12'd0);
        @(negedge clk);
        check("lat_vld", 12'(snk_vld), 12'd1);
        check("ramp_777", snk_rgb, 12'h777);
        @(posedge clk);
        #1;
    endtask

    task automatic pal_wr(input logic [S-1:0] a, input logic [W-1:0] d);
        pal_write    = 1'b1;
        pal_addr     = a;
        pal_wdata    = d;
        pal_model[a] = d;
        @(posedge clk);
        #1;
        pal_write = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] pix);
        int t;
        t       = 0;
        src_vld = 1'b1;
        src_rgb = pix;
        @(negedge clk);
        while (!src_rdy && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!src_rdy) check("send_timeout", 12'(src_rdy), 12'd1);
        @(posedge clk);
        #1;
        src_vld = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        snk_rdy = 1'b1;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", 12'(exp_q.size()), 12'd0);
    endtask

    initial begin
        src_rgb   = '0;
        src_vld   = 1'b0;
        snk_rdy   = 1'b1;
        pal_write = 1'b0;
        pal_addr  = '0;
        pal_wdata = '0;
        #2;
        apply_reset();
        run_init();
        drain();

        // Programmed entry followed by an identity entry, back to back.
        pal_wr(4'd3, 12'hF00);
        send(12'h333);
        send(12'h555);
        @(negedge clk);
        check("b2b_first_vld", 12'(snk_vld), 12'd1);
        check("b2b_first_rgb", snk_rgb, 12'hF00);
        @(negedge clk);
        check("b2b_second_vld", 12'(snk_vld), 12'd1);
        check("b2b_second_rgb", snk_rgb, 12'h555);
        drain();

        // Write to entry 5 on the edge where a gray-5 pixel leaves stage 0.
        send(12'h555);
        pal_write    = 1'b1;
        pal_addr     = 4'd5;
        pal_wdata    = 12'h0F0;
        pal_model[5] = 12'h0F0;
        send(12'h555);
        pal_write = 1'b0;
        @(negedge clk);
        check("collide_old", snk_rgb, 12'h555);
        @(negedge clk);
        check("collide_new", snk_rgb, 12'h0F0);
        drain();

        // Four-cycle output stall right after the first output appears.
        fork
            begin
                send(12'h111);
                send(12'h222);
                send(12'h333);
            end
            begin
                int t;
                t = 0;
                do begin
                    @(posedge clk);
                    #1;
                    t++;
                end while (!snk_vld && t < 50);
                check("stall_first_out", 12'(snk_vld), 12'd1);
                snk_rdy = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_src_rdy", 12'(src_rdy), 12'd0);
                    check("stall_hold_rgb", snk_rgb, 12'h111);
                end
                @(posedge clk);
                #1;
                snk_rdy = 1'b1;
            end
        join
        drain();

`ifdef VIDEO_GRAY2RGB_BYPASS_EN
        pal_wr(4'd9, 12'h00F);
        byp_drv = 1'b1;
        send(12'h999);
        byp_drv = 1'b0;
        send(12'h999);
        @(negedge clk);
        check("bypass_on", snk_rgb, 12'h999);
        @(negedge clk);
        check("bypass_off", snk_rgb, 12'h00F);
        drain();
`endif

        // Randomized palette contents, pixels, gaps and backpressure.
        for (int k = 0; k < 6; k++) begin
            pal_wr(4'($urandom_range(0, 15)), 12'($urandom));
        end
        begin
            bit done;
            done = 1'b0;
            fork
                begin
                    for (int k = 0; k < 200; k++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
`ifdef VIDEO_GRAY2RGB_BYPASS_EN
                        byp_drv = 1'($urandom_range(0, 1));
`endif
                        send({4'($urandom_range(0, 15)), 8'($urandom)});
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1;
                        snk_rdy = ($urandom_range(0, 3) != 0);
                    end
                end
            join
        end
`ifdef VIDEO_GRAY2RGB_BYPASS_EN
        byp_drv = 1'b0;
`endif
        drain();

        // Reset while pixels are in flight, then again part-way through INIT.
        src_vld = 1'b1;
        src_rgb = 12'h4AB;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_vld", 12'(snk_vld), 12'd1);
        apply_reset();
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        apply_reset();
        run_init();
        send(12'h333);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
